eth_fcs_checker: RTL and testbench

- Receive-side counterpart of the byte-wide Ethernet CRC generator.
- Consumes a layer-1 byte stream: preamble, SFD, frame, FCS.
- Checks the preamble and SFD, recomputes CRC-32 over the frame including the FCS, and strips preamble/SFD/FCS from the payload output.
- Emits one status pulse per frame (CRC, runt, oversize, SFD flags). Sits between the PHY-side byte receiver and the frame parser/capture logic. No backpressure; one byte per cycle maximum.

---
 rtl/eth_fcs_checker.sv | 136 +++++++++++++
 tb/tb_eth_fcs_checker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_fcs_checker.sv
// Receive-side Ethernet FCS checker: validates preamble/SFD, checks the CRC-32 residue,
// strips preamble/SFD/FCS from the byte stream and reports one status pulse per transfer.
module eth_fcs_checker #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_last,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             status_valid,
  output logic             status_good,
  output logic             status_crc_err,
  output logic             status_runt,
  output logic             status_long,
  output logic             status_sfd_err,
  output logic [LEN_W-1:0] status_len
);

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t                 state;
  logic [31:0]            crc;
  logic [LEN_W-1:0]       len;
  logic [2:0]             hold_cnt;
  logic [3:0][7:0]        hold;     // hold[3] is the oldest byte

  logic [31:0]            crc_nxt;
  logic [LEN_W-1:0]       len_nxt;
  logic                   crc_bad, is_runt, is_long;

  // Reflected CRC-32, one byte per call, data LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    crc_nxt = crc_byte(crc, rx_data);
    len_nxt = (&len) ? len : len + 1'b1;
    crc_bad = (crc_nxt != CRC_RESIDUE);
    is_runt = (len_nxt < LEN_W'(MIN_FRAME));
    is_long = (len_nxt > LEN_W'(MAX_FRAME));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      crc            <= CRC_INIT;
      len            <= '0;
      hold_cnt       <= '0;
      hold           <= '0;
      m_data         <= '0;
      m_valid        <= 1'b0;
      m_last         <= 1'b0;
      status_valid   <= 1'b0;
      status_good    <= 1'b0;
      status_crc_err <= 1'b0;
      status_runt    <= 1'b0;
      status_long    <= 1'b0;
      status_sfd_err <= 1'b0;
      status_len     <= '0;
    end else begin
      // Pulses and flags are only asserted in the cycle after an accepted byte.
      m_valid        <= 1'b0;
      m_last         <= 1'b0;
      status_valid   <= 1'b0;
      status_good    <= 1'b0;
      status_crc_err <= 1'b0;
      status_runt    <= 1'b0;
      status_long    <= 1'b0;
      status_sfd_err <= 1'b0;
      status_len     <= '0;

      if (rx_valid) begin
        case (state)
          IDLE, PREAMBLE: begin
            if (rx_data == SFD_BYTE) begin
              state    <= DATA;
              crc      <= CRC_INIT;
              len      <= '0;
              hold_cnt <= '0;
            end else if (rx_data == PRE_BYTE) begin
              state <= PREAMBLE;
            end else begin
              state <= DROP;
            end
          end
          DATA: begin
            crc  <= crc_nxt;
            len  <= len_nxt;
            hold <= {hold[2:0], rx_data};
            // Four bytes stay in flight so the trailing FCS never reaches the output.
            if (hold_cnt == 3'd4) begin
              m_valid <= 1'b1;
              m_data  <= hold[3];
              m_last  <= rx_last;
            end else begin
              hold_cnt <= hold_cnt + 3'd1;
            end
          end
          default: ;
        endcase

        if (rx_last) begin
          state        <= IDLE;
          status_valid <= 1'b1;
          if (state == DATA) begin
            status_crc_err <= crc_bad;
            status_runt    <= is_runt;
            status_long    <= is_long;
            status_good    <= !(crc_bad | is_runt | is_long);
            status_len     <= len_nxt;
          end else begin
            status_sfd_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_fcs_checker.sv
// Directed bench for eth_fcs_checker: builds layer-1 streams with a bench-side FCS
// generator and checks the stripped payload and per-frame status against expectations.
module tb_eth_fcs_checker;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_last;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_last;
  logic             status_valid;
  logic             status_good;
  logic             status_crc_err;
  logic             status_runt;
  logic             status_long;
  logic             status_sfd_err;
  logic [LEN_W-1:0] status_len;

  always #5 clk = ~clk;

  eth_fcs_checker #(.MIN_FRAME(64), .MAX_FRAME(1518), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .status_valid(status_valid), .status_good(status_good),
    .status_crc_err(status_crc_err), .status_runt(status_runt),
    .status_long(status_long), .status_sfd_err(status_sfd_err),
    .status_len(status_len)
  );

  typedef struct packed {
    logic        good, crc, runt, lng, sfd;
    logic [15:0] len;
  } st_t;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  beats[$];
  int          lasts[$];
  st_t         stats[$];
  int          stray = 0;
  logic [8:0]  tx_q[$];   // {last, data}
  logic [7:0]  pay[$];
  logic [7:0]  expd[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Outputs change only on posedge; rx_* still hold the values sampled at that edge here.
  always @(negedge clk) begin
    if (m_valid) begin
      if (m_last) lasts.push_back(beats.size());
      beats.push_back(m_data);
    end
    if (status_valid)
      stats.push_back('{status_good, status_crc_err, status_runt, status_long,
                        status_sfd_err, status_len});
    if ((m_valid || status_valid) && !rx_valid) stray++;
  end

  function automatic logic [31:0] fcs_of();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (pay[k])
      for (int b = 0; b < 8; b++)
        c = (c[0] ^ pay[k][b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return ~c;
  endfunction

  task automatic make_pay(input int n, input int seed);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'(i * 13 + seed));
  endtask

  task automatic put(input logic [7:0] d, input logic l);
    tx_q.push_back({l, d});
  endtask

  // Appends preamble, SFD, payload (optionally one byte flipped) and FCS of the clean payload.
  task automatic add_frame(input int flip_idx, input bit good_sfd);
    logic [31:0] f;
    logic [7:0]  b;
    f = fcs_of();
    for (int i = 0; i < 7; i++) put(8'h55, 1'b0);
    put(good_sfd ? 8'hD5 : 8'hD4, 1'b0);
    foreach (pay[i]) begin
      b = (i == flip_idx) ? (pay[i] ^ 8'h01) : pay[i];
      put(b, 1'b0);
      if (good_sfd) expd.push_back(b);
    end
    for (int i = 0; i < 4; i++) put(f[8*i +: 8], i == 3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      rx_valid = 1'b0; rx_last = 1'b0;
    end
  endtask

  task automatic send(input bit gaps);
    int cyc;
    cyc = 0;
    while (tx_q.size() > 0) begin
      @(negedge clk); #1;
      if (gaps && (cyc % 3 == 2)) begin
        rx_valid = 1'b0; rx_last = 1'b0; rx_data = 8'hXX;
      end else begin
        {rx_last, rx_data} = tx_q.pop_front();
        rx_valid = 1'b1;
      end
      cyc++;
    end
    idle(4);
  endtask

  task automatic clear_mon();
    beats.delete(); lasts.delete(); stats.delete(); expd.delete(); stray = 0;
  endtask

  task automatic chk_beats(input string tag);
    int bad;
    bad = 0;
    chk({tag, ".beats"}, beats.size(), expd.size());
    foreach (expd[i]) if (i >= beats.size() || beats[i] !== expd[i]) bad++;
    chk({tag, ".data_mismatch"}, bad, 0);
    if (expd.size() > 0) begin
      chk({tag, ".nlast"}, lasts.size(), 1);
      if (lasts.size() > 0) chk({tag, ".last_pos"}, lasts[0], expd.size() - 1);
    end else begin
      chk({tag, ".nlast"}, lasts.size(), 0);
    end
    chk({tag, ".stray"}, stray, 0);
  endtask

  task automatic chk_stat(input string tag, input int idx, input st_t e);
    if (idx < stats.size()) begin
      chk({tag, ".flags"}, {stats[idx].good, stats[idx].crc, stats[idx].runt,
                            stats[idx].lng, stats[idx].sfd},
                           {e.good, e.crc, e.runt, e.lng, e.sfd});
      chk({tag, ".len"}, stats[idx].len, e.len);
    end else begin
      chk({tag, ".status_missing"}, stats.size(), idx + 1);
    end
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_last = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset.outputs", {m_data, m_valid, m_last, status_valid, status_good, status_crc_err,
                          status_runt, status_long, status_sfd_err, status_len}, 32'h0);
    #1 reset = 1'b0;
    idle(2);

    // Good 64-byte frame
    clear_mon(); make_pay(60, 1); add_frame(-1, 1); send(0);
    chk_beats("good"); chk("good.nstat", stats.size(), 1);
    chk_stat("good", 0, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd64});

    // Corrupted payload byte 20, FCS of the clean payload
    clear_mon(); make_pay(60, 1); add_frame(20, 1); send(0);
    chk_beats("corrupt");
    chk_stat("corrupt", 0, '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd64});

    // Runt with correct FCS
    clear_mon(); make_pay(59, 5); add_frame(-1, 1); send(0);
    chk_beats("runt63");
    chk_stat("runt63", 0, '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd63});

    // Three bytes after SFD
    clear_mon();
    for (int i = 0; i < 7; i++) put(8'h55, 1'b0);
    put(8'hD5, 1'b0); put(8'h01, 1'b0); put(8'h02, 1'b0); put(8'h03, 1'b1);
    send(0);
    chk_beats("runt3");
    chk_stat("runt3", 0, '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3});

    // Bad SFD, then a good frame the very next cycle
    clear_mon(); make_pay(10, 9); add_frame(-1, 0);
    make_pay(60, 2); add_frame(-1, 1); send(0);
    chk_beats("sfd_b2b"); chk("sfd_b2b.nstat", stats.size(), 2);
    chk_stat("sfd_bad", 0, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0});
    chk_stat("sfd_next", 1, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd64});

    // rx_valid low every third cycle
    clear_mon(); make_pay(60, 1); add_frame(-1, 1); send(1);
    chk_beats("gaps");
    chk_stat("gaps", 0, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd64});

    // Maximum legal length, and one byte over
    clear_mon(); make_pay(1514, 3); add_frame(-1, 1); send(0);
    chk_beats("max1518");
    chk_stat("max1518", 0, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1518});
    clear_mon(); make_pay(1515, 4); add_frame(-1, 1); send(0);
    chk_beats("long1519");
    chk_stat("long1519", 0, '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1519});

    // Reset during payload byte 30
    clear_mon(); make_pay(60, 7); add_frame(-1, 1);
    for (int i = 0; i < 38; i++) begin
      @(negedge clk); #1;
      {rx_last, rx_data} = tx_q.pop_front(); rx_valid = 1'b1;
    end
    @(negedge clk); #1;
    reset = 1'b1; {rx_last, rx_data} = tx_q.pop_front(); rx_valid = 1'b1;
    @(negedge clk);
    chk("midrst.outputs", {m_data, m_valid, m_last, status_valid, status_good, status_crc_err,
                           status_runt, status_long, status_sfd_err, status_len}, 32'h0);
    #1 reset = 1'b0; rx_valid = 1'b0; rx_last = 1'b0;
    tx_q.delete();
    idle(4);
    chk("midrst.beats", beats.size(), 26);
    chk("midrst.nstat", stats.size(), 0);
    chk("midrst.nlast", lasts.size(), 0);

    clear_mon(); make_pay(60, 11); add_frame(-1, 1); send(0);
    chk_beats("after_rst");
    chk_stat("after_rst", 0, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd64});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
